// File: rtl/mem_pkg.sv
// Shared memory-interface types: the arbiter FSM states and the transaction owner.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational IF/LSU grant with LSU priority and an IF starvation guard.
module mem_arb_prio #(
  parameter int unsigned MAX_SKIP = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en,
  input  logic if_req,
  input  logic lsu_req,
  output logic if_gnt,
  output logic lsu_gnt
);

  localparam logic [3:0] SKIP_LIMIT = 4'(MAX_SKIP);

  logic [3:0] skip_q;
  logic       if_forced;

  always_comb begin
    if_forced = if_req && (skip_q == SKIP_LIMIT);
    lsu_gnt   = arb_en && lsu_req && !if_forced;
    if_gnt    = arb_en && if_req && !lsu_gnt;
  end

  // Counts only LSU grants that made a waiting IF lose; saturates at the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skip_q <= '0;
    end else if (if_gnt) begin
      skip_q <= '0;
    end else if (lsu_gnt && if_req && (skip_q != SKIP_LIMIT)) begin
      skip_q <= skip_q + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit,
// one transaction at a time, with registered memory outputs and routed responses.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_SKIP = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  state_e state_q, state_d;
  owner_e owner_q;
  logic   we_q;
  logic   arb_en, any_gnt, done;

  always_comb begin
    arb_en  = (state_q == ST_IDLE) || (state_q == ST_RESP);
    any_gnt = if_gnt_o || lsu_gnt_o;
    done    = (state_q == ST_BUSY) && mem_ready_i;
  end

  mem_arb_prio #(
    .MAX_SKIP(MAX_SKIP)
  ) u_prio (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .arb_en  (arb_en),
    .if_req  (if_req_i),
    .lsu_req (lsu_req_i),
    .if_gnt  (if_gnt_o),
    .lsu_gnt (lsu_gnt_o)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_gnt) state_d = ST_BUSY;
      ST_BUSY: if (mem_ready_i) state_d = ST_RESP;
      ST_RESP: state_d = any_gnt ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // we_q keeps the store flag for response routing after mem_we_o has dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_be_o     <= '0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      if_rvalid_o  <= 1'b0;
      if_rdata_o   <= '0;
      lsu_rvalid_o <= 1'b0;
      lsu_rdata_o  <= '0;
    end else begin
      if_rvalid_o  <= done && (owner_q == OWN_IF);
      lsu_rvalid_o <= done && (owner_q == OWN_LSU);
      if (done) begin
        mem_req_o <= 1'b0;
        mem_we_o  <= 1'b0;
        if (owner_q == OWN_IF) if_rdata_o  <= mem_rdata_i;
        else                   lsu_rdata_o <= we_q ? '0 : mem_rdata_i;
      end
      if (lsu_gnt_o) begin
        owner_q     <= OWN_LSU;
        we_q        <= lsu_we_i;
        mem_req_o   <= 1'b1;
        mem_we_o    <= lsu_we_i;
        mem_be_o    <= lsu_we_i ? lsu_be_i : '1;
        mem_addr_o  <= lsu_addr_i;
        mem_wdata_o <= lsu_wdata_i;
      end else if (if_gnt_o) begin
        owner_q    <= OWN_IF;
        we_q       <= 1'b0;
        mem_req_o  <= 1'b1;
        mem_we_o   <= 1'b0;
        mem_be_o   <= '1;
        mem_addr_o <= if_addr_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, response scoreboard and corner sequences.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i, lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_gnt_o, lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_SKIP(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          lsu;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned waitc;
    logic [31:0] rd;
    logic [3:0]  exp_be;
    bit          exp_we;
    logic [31:0] exp_rdata;
    int unsigned exp_cycles;
  } vec_t;

  typedef struct {
    bit          lsu;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_mem_t;

  int          checks = 0;
  int          errors = 0;
  sb_t         sb[$];
  exp_mem_t    em;
  int unsigned wait_cfg = 0;
  logic [31:0] rd_cfg = '0;
  logic        poke = 1'b0;
  logic [31:0] last_if, last_lsu;
  vec_t        vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  // Memory model: answers with rd_cfg after wait_cfg wait cycles; poke forces a stray ready.
  initial begin
    int unsigned cnt;
    logic auto_rdy;
    cnt = 0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'hEEEE_EEEE;
    forever begin
      @(posedge clk_i);
      #2;
      auto_rdy = 1'b0;
      if (mem_req_o && !rst_i) begin
        if (cnt >= wait_cfg) begin
          auto_rdy = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
      mem_ready_i = auto_rdy | poke;
      mem_rdata_i = auto_rdy ? rd_cfg : 32'hEEEE_EEEE;
    end
  end

  // Scoreboard monitor: responses are popped before the same-cycle grant is pushed.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (if_rvalid_o || lsu_rvalid_o) begin
          chk("rvalid_onehot", {31'd0, if_rvalid_o & lsu_rvalid_o}, 32'd0);
          if (sb.size() == 0) begin
            fail("sb_unexpected_rvalid");
          end else begin
            e = sb.pop_front();
            chk("sb_owner", {31'd0, lsu_rvalid_o}, {31'd0, e.lsu});
            chk("sb_rdata", lsu_rvalid_o ? lsu_rdata_o : if_rdata_o, e.data);
          end
        end
        if (mem_req_o) begin
          chk("mon_mem_addr", mem_addr_o, em.addr);
          chk("mon_mem_we", {31'd0, mem_we_o}, {31'd0, em.we});
          chk("mon_mem_be", {28'd0, mem_be_o}, {28'd0, em.be});
          if (em.we) chk("mon_mem_wdata", mem_wdata_o, em.wdata);
        end
        if (if_gnt_o || lsu_gnt_o) begin
          chk("gnt_onehot", {31'd0, if_gnt_o & lsu_gnt_o}, 32'd0);
          if (lsu_gnt_o) begin
            e.lsu   = 1'b1;
            e.data  = lsu_we_i ? 32'd0 : rd_cfg;
            em.addr = lsu_addr_i;
            em.we   = lsu_we_i;
            em.be   = lsu_we_i ? lsu_be_i : 4'hF;
            em.wdata = lsu_wdata_i;
          end else begin
            e.lsu   = 1'b0;
            e.data  = rd_cfg;
            em.addr = if_addr_i;
            em.we   = 1'b0;
            em.be   = 4'hF;
            em.wdata = '0;
          end
          sb.push_back(e);
        end
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int unsigned req_cnt;
    bit got;
    rd_cfg   = v.rd;
    wait_cfg = v.waitc;
    @(posedge clk_i);
    #1;
    if (v.lsu) begin
      lsu_req_i = 1'b1; lsu_we_i = v.we; lsu_be_i = v.be;
      lsu_addr_i = v.addr; lsu_wdata_i = v.wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = v.addr;
    end
    @(negedge clk_i);
    chk($sformatf("v%0d_if_gnt", idx), {31'd0, if_gnt_o}, {31'd0, !v.lsu});
    chk($sformatf("v%0d_lsu_gnt", idx), {31'd0, lsu_gnt_o}, {31'd0, v.lsu});
    @(posedge clk_i);
    #1;
    if_req_i = 1'b0; lsu_req_i = 1'b0;
    if_addr_i = $urandom; lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
    lsu_we_i = ~v.we; lsu_be_i = ~v.be;
    @(negedge clk_i);
    chk($sformatf("v%0d_mem_addr", idx), mem_addr_o, v.addr);
    chk($sformatf("v%0d_mem_we", idx), {31'd0, mem_we_o}, {31'd0, v.exp_we});
    chk($sformatf("v%0d_mem_be", idx), {28'd0, mem_be_o}, {28'd0, v.exp_be});
    if (v.exp_we) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata_o, v.wdata);
    req_cnt = mem_req_o ? 1 : 0;
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk_i);
      if (mem_req_o) req_cnt++;
      if (if_rvalid_o || lsu_rvalid_o) begin
        got = 1;
        chk($sformatf("v%0d_req_cycles", idx), req_cnt, v.exp_cycles);
        if (v.lsu) begin
          chk($sformatf("v%0d_lsu_rvalid", idx), {31'd0, lsu_rvalid_o}, 32'd1);
          chk($sformatf("v%0d_lsu_rdata", idx), lsu_rdata_o, v.exp_rdata);
          chk($sformatf("v%0d_if_rdata_hold", idx), if_rdata_o, last_if);
          last_lsu = v.exp_rdata;
        end else begin
          chk($sformatf("v%0d_if_rvalid", idx), {31'd0, if_rvalid_o}, 32'd1);
          chk($sformatf("v%0d_if_rdata", idx), if_rdata_o, v.exp_rdata);
          chk($sformatf("v%0d_lsu_rdata_hold", idx), lsu_rdata_o, last_lsu);
          last_if = v.exp_rdata;
        end
      end
    end
    if (!got) fail($sformatf("v%0d_rvalid_timeout", idx));
  endtask

  initial begin
    bit exp_order[8];
    int n, last_c, rv;
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
    last_if = '0; last_lsu = '0;
    em = '{addr: '0, we: 1'b0, be: '0, wdata: '0};

    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'hDEAD_BEEF, 1};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'h1234_5678, 3, 32'hCAFE_F00D, 4'h3, 1'b1, 32'h0,         4};
    vecs[2] = '{1'b1, 1'b0, 4'h4, 32'h0000_0200, 32'h9999_0000, 1, 32'h55AA_33CC, 4'hF, 1'b0, 32'h55AA_33CC, 2};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         2, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0BAD_F00D, 3};
    vecs[4] = '{1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'hA5A5_A5A5, 0, 32'h7777_7777, 4'hF, 1'b1, 32'h0,         1};

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    chk("rst_rvalids", {30'd0, if_rvalid_o, lsu_rvalid_o}, 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_lsu_rdata", lsu_rdata_o, 32'd0);
    chk("rst_gnts", {30'd0, if_gnt_o, lsu_gnt_o}, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Both requesters held high with zero-wait memory: starvation guard ordering.
    rd_cfg = 32'h600D_0000;
    wait_cfg = 0;
    @(posedge clk_i);
    #1;
    if_req_i = 1'b1; if_addr_i = 32'h40;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_addr_i = 32'h80;
    n = 0;
    last_c = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      @(negedge clk_i);
      if (if_gnt_o || lsu_gnt_o) begin
        chk($sformatf("order%0d_lsu", n), {31'd0, lsu_gnt_o}, {31'd0, exp_order[n]});
        if (n > 0) chk($sformatf("order%0d_gap", n), c - last_c, 32'd2);
        last_c = c;
        n++;
      end
    end
    if (n < 8) fail("order_timeout");
    @(posedge clk_i);
    #1;
    if_req_i = 1'b0; lsu_req_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("order_sb_drained", sb.size(), 32'd0);

    // Reset in the middle of a long transaction.
    rd_cfg = 32'h1111_2222;
    wait_cfg = 6;
    @(posedge clk_i);
    #1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h300;
    @(negedge clk_i);
    chk("rstmid_gnt", {31'd0, lsu_gnt_o}, 32'd1);
    @(posedge clk_i);
    #1;
    lsu_req_i = 1'b0;
    @(posedge clk_i);
    #3;
    chk("rstmid_busy", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rstmid_async_req", {31'd0, mem_req_o}, 32'd0);
    chk("rstmid_async_addr", mem_addr_o, 32'd0);
    sb.delete();
    last_if = '0; last_lsu = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
    rv = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (if_rvalid_o || lsu_rvalid_o) rv++;
    end
    chk("rstmid_no_rvalid", rv, 32'd0);

    // Stray mem_ready in IDLE must be ignored.
    wait_cfg = 0;
    @(posedge clk_i);
    #1;
    poke = 1'b1;
    @(posedge clk_i);
    #1;
    poke = 1'b0;
    rv = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      if (if_rvalid_o || lsu_rvalid_o || mem_req_o || mem_we_o) rv++;
      if (mem_be_o != 4'h0 || mem_addr_o != 32'h0 || mem_wdata_o != 32'h0) rv++;
      if (if_rdata_o != 32'h0 || lsu_rdata_o != 32'h0) rv++;
    end
    chk("poke_outputs_zero", rv, 32'd0);

    // First request after that is granted straight from IDLE.
    run_vec(5, vecs[0]);

    repeat (3) @(negedge clk_i);
    chk("final_sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
